mem_access_ctrl: RTL and testbench

//   Sequences every RAM transaction through the memory address register (MAR) and the 512-word RAM.

---
 rtl/mem_access_ctrl_if.sv | 40 ++++
 rtl/mem_access_ctrl.sv | 119 +++++++++++
 tb/tb_mem_access_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Requester, MAR and RAM signals of the memory access controller.
// master = requesters plus RAM side; slave = the controller.
interface mem_access_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              req0;
  logic              we0;
  logic [DATA_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              req1;
  logic              we1;
  logic [DATA_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              mar_en;
  logic [DATA_W-1:0] mar_d;
  logic              ram_read;
  logic              ram_write;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_rdata,
    input  ack0, ack1, rdata, mar_en, mar_d,
    input  ram_read, ram_write, ram_wdata, busy
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_rdata,
    output ack0, ack1, rdata, mar_en, mar_d,
    output ram_read, ram_write, ram_wdata, busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Round-robin arbiter and sequencer for MAR/RAM transactions from two requesters
// (port 0 instruction fetch, port 1 load/store).
module mem_access_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int RAM_LAT = 2
) (
  input logic             clock,
  input logic             clear,
  mem_access_ctrl_if.slave bus
);

  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RAM_LAT - 1);

  if (RAM_LAT < 1 || ADDR_W > DATA_W) begin : g_param_check
    $error("mem_access_ctrl: RAM_LAT must be >= 1 and ADDR_W <= DATA_W");
  end

  typedef enum logic [1:0] {IDLE, LOAD, ACCESS, RESP} state_t;

  state_t            state, next_state;
  logic              last_grant;
  logic [CNT_W-1:0]  cnt;
  logic              id_q;
  logic              we_q;
  logic [DATA_W-1:0] mar_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic grant;
  logic grant_port;
  logic mar_en_c;
  logic ram_read_c;
  logic ram_write_c;
  logic ack0_c;
  logic ack1_c;
  logic last_access;

  assign last_access = (state == ACCESS) && (cnt == LAST_CNT);

  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= next_state;
  end

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    next_state  = state;
    grant       = 1'b0;
    grant_port  = 1'b0;
    mar_en_c    = 1'b0;
    ram_read_c  = 1'b0;
    ram_write_c = 1'b0;
    ack0_c      = 1'b0;
    ack1_c      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant      = 1'b1;
          next_state = LOAD;
          if (bus.req0 && bus.req1) grant_port = ~last_grant;
          else                      grant_port = bus.req1;
        end
      end
      LOAD: begin
        mar_en_c   = 1'b1;
        next_state = ACCESS;
      end
      ACCESS: begin
        ram_read_c  = ~we_q;
        ram_write_c = we_q;
        if (cnt == LAST_CNT) next_state = RESP;
      end
      RESP: begin
        ack0_c     = ~id_q;
        ack1_c     = id_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      last_grant <= 1'b1;
      cnt        <= '0;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      mar_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      if (grant) begin
        last_grant <= grant_port;
        id_q       <= grant_port;
        we_q       <= grant_port ? bus.we1    : bus.we0;
        mar_q      <= grant_port ? bus.addr1  : bus.addr0;
        wdata_q    <= grant_port ? bus.wdata1 : bus.wdata0;
      end
      if (state == ACCESS) begin
        if (cnt == LAST_CNT) cnt <= '0;
        else                 cnt <= cnt + 1'b1;
      end
      if (last_access && !we_q) rdata_q <= bus.ram_rdata;
    end
  end

  assign bus.ack0      = ack0_c;
  assign bus.ack1      = ack1_c;
  assign bus.rdata     = rdata_q;
  assign bus.mar_en    = mar_en_c;
  assign bus.mar_d     = mar_q;
  assign bus.ram_read  = ram_read_c;
  assign bus.ram_write = ram_write_c;
  assign bus.ram_wdata = wdata_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a 512-word RAM model behind the MAR and a
// scoreboard of expected (port, rdata) pairs that is consumed on every ack.
module tb_mem_access_ctrl;

  logic clock = 1'b0;
  logic clear;

  always #5 clock = ~clock;

  mem_access_ctrl_if #(.DATA_W(32)) bus ();

  mem_access_ctrl #(
    .DATA_W (32),
    .ADDR_W (9),
    .RAM_LAT(2)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus.slave)
  );

  typedef struct {
    int          port;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] exp_rdata  = 32'h0;

  // Power-up contents shared by the RAM model and the reference memory.
  function automatic logic [31:0] init_word(input logic [8:0] a);
    if (a == 9'd5) return 32'hDEADBEEF;
    return 32'hC0DE0000 | {23'b0, a};
  endfunction

  bit [31:0]  ram_mem [512];
  bit         ram_wr  [512];
  logic [8:0] ram_mar = 9'h0;

  always @(posedge clock) begin
    if (bus.mar_en) ram_mar <= bus.mar_d[8:0];
    if (bus.ram_write) begin
      ram_mem[ram_mar] <= bus.ram_wdata;
      ram_wr[ram_mar]  <= 1'b1;
    end
  end

  assign bus.ram_rdata = bus.ram_read ?
                         (ram_wr[ram_mar] ? ram_mem[ram_mar] : init_word(ram_mar)) : 32'h0;

  bit [31:0] ref_mem [512];
  bit        ref_wr  [512];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    exp_t e;
    if (we) begin
      ref_mem[addr[8:0]] = wdata;
      ref_wr[addr[8:0]]  = 1'b1;
    end else begin
      exp_rdata = ref_wr[addr[8:0]] ? ref_mem[addr[8:0]] : init_word(addr[8:0]);
    end
    e.port  = port;
    e.rdata = exp_rdata;
    sb.push_back(e);
  endtask

  task automatic drive_req(input int port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    if (port == 0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end
  endtask

  task automatic apply_stimulus(input int port, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata);
    drive_req(port, we, addr, wdata);
    push_exp(port, we, addr, wdata);
  endtask

  task automatic drop_req(input int port);
    if (port == 0) bus.req0 = 1'b0;
    else           bus.req1 = 1'b0;
  endtask

  task automatic cycle(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  // port 2 means either ack; the bound turns a lost ack into a failed comparison.
  task automatic wait_ack(input int port, input string tag);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 12 && !seen; n++) begin
      @(negedge clock);
      if (port == 0)      seen = bus.ack0;
      else if (port == 1) seen = bus.ack1;
      else                seen = bus.ack0 | bus.ack1;
    end
    check_output(tag, {31'b0, seen}, 32'h1);
  endtask

  task automatic do_reset();
    clear = 1'b1;
    cycle(2);
    clear     = 1'b0;
    exp_rdata = 32'h0;
  endtask

  // Every ack consumes the oldest expectation: grant order and returned data.
  always @(negedge clock) begin
    if (bus.ack0 || bus.ack1) begin
      if (sb.size() == 0) begin
        check_output("unexpected_ack", {30'b0, bus.ack1, bus.ack0}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check_output("ack_port", {30'b0, bus.ack1, bus.ack0}, (mon_e.port == 0) ? 32'h1 : 32'h2);
        check_output("ack_rdata", bus.rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    do_reset();

    check_output("reset_ctrl", {26'b0, bus.busy, bus.ack0, bus.ack1, bus.mar_en,
                                bus.ram_read, bus.ram_write}, 32'h0);
    check_output("reset_rdata", bus.rdata, 32'h0);
    check_output("reset_mar_d", bus.mar_d, 32'h0);
    check_output("reset_ram_wdata", bus.ram_wdata, 32'h0);
    cycle();

    $display("[TB] port 0 read of address 5");
    apply_stimulus(0, 1'b0, 32'h5, 32'h0);
    cycle();
    check_output("t1_load_strobes", {29'b0, bus.mar_en, bus.ram_read, bus.ram_write}, 32'h4);
    check_output("t1_mar_d", bus.mar_d, 32'h5);
    cycle();
    check_output("t1_access1", {29'b0, bus.mar_en, bus.ram_read, bus.ram_write}, 32'h2);
    cycle();
    check_output("t1_access2", {29'b0, bus.mar_en, bus.ram_read, bus.ram_write}, 32'h2);
    cycle();
    check_output("t1_ack_cycle4", {30'b0, bus.ack1, bus.ack0}, 32'h1);
    drop_req(0);
    cycle();
    check_output("t1_idle_after", {30'b0, bus.busy, bus.ack0}, 32'h0);

    $display("[TB] port 1 write to 0x1FF then read back");
    apply_stimulus(1, 1'b1, 32'h1FF, 32'h12345678);
    cycle();
    check_output("t2_mar_d", bus.mar_d, 32'h1FF);
    cycle();
    check_output("t2_access1", {29'b0, bus.mar_en, bus.ram_read, bus.ram_write}, 32'h1);
    check_output("t2_ram_wdata", bus.ram_wdata, 32'h12345678);
    cycle();
    check_output("t2_access2", {29'b0, bus.mar_en, bus.ram_read, bus.ram_write}, 32'h1);
    cycle();
    check_output("t2_ack_cycle4", {30'b0, bus.ack1, bus.ack0}, 32'h2);
    drop_req(1);
    cycle();
    apply_stimulus(1, 1'b0, 32'h1FF, 32'h0);
    wait_ack(1, "t2_readback_ack");
    drop_req(1);
    cycle();

    $display("[TB] simultaneous requests after reset");
    do_reset();
    apply_stimulus(0, 1'b0, 32'h5, 32'h0);
    apply_stimulus(1, 1'b0, 32'h1FF, 32'h0);
    cycle(4);
    check_output("t3_ack0_cycle4", {30'b0, bus.ack1, bus.ack0}, 32'h1);
    drop_req(0);
    cycle();
    check_output("t3_idle_cycle5", {31'b0, bus.busy}, 32'h0);
    cycle();
    check_output("t3_load_cycle6", {31'b0, bus.mar_en}, 32'h1);
    check_output("t3_mar_d_port1", bus.mar_d, 32'h1FF);
    cycle(3);
    check_output("t3_ack1_cycle9", {30'b0, bus.ack1, bus.ack0}, 32'h2);
    drop_req(1);
    cycle();

    $display("[TB] both ports holding requests alternate");
    apply_stimulus(0, 1'b0, 32'h10, 32'h0);
    apply_stimulus(1, 1'b0, 32'h20, 32'h0);
    push_exp(0, 1'b0, 32'h10, 32'h0);
    push_exp(1, 1'b0, 32'h20, 32'h0);
    for (int k = 0; k < 4; k++) begin
      wait_ack(2, "t4_ack");
      check_output("t4_grant_order", {30'b0, bus.ack1, bus.ack0}, (k % 2 == 0) ? 32'h1 : 32'h2);
    end
    drop_req(0);
    drop_req(1);
    cycle();

    $display("[TB] write above ADDR_W aliases to low address");
    apply_stimulus(1, 1'b1, 32'hFFFFFE03, 32'hA5A5A5A5);
    cycle();
    check_output("t5_mar_d_full", bus.mar_d, 32'hFFFFFE03);
    wait_ack(1, "t5_write_ack");
    drop_req(1);
    cycle();
    apply_stimulus(0, 1'b0, 32'h3, 32'h0);
    wait_ack(0, "t5_read_ack");
    drop_req(0);
    cycle();

    $display("[TB] clear during read access");
    drive_req(0, 1'b0, 32'h5, 32'h0);
    cycle(2);
    check_output("t6_in_access", {29'b0, bus.mar_en, bus.ram_read, bus.ram_write}, 32'h2);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    drop_req(0);
    exp_rdata = 32'h0;
    check_output("t6_after_clear", {27'b0, bus.busy, bus.ack0, bus.ack1,
                                    bus.ram_read, bus.ram_write}, 32'h0);
    check_output("t6_rdata_cleared", bus.rdata, 32'h0);
    cycle(4);
    apply_stimulus(0, 1'b0, 32'h1FF, 32'h0);
    wait_ack(0, "t6_recover_ack");
    drop_req(0);
    cycle(2);

    check_output("sb_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
